// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// fifo_rd_stream -- drains a 1-cycle-latency FIFO read port into a
// valid/ready stream through a 2-entry output buffer.
// Revision: 1.0
// ============================================================================
module fifo_rd_stream #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          re,
  input  logic [W-1:0]  rd,
  input  logic          rempty,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] xfer_cnt
);

  localparam logic [1:0]    c_CNT_EMPTY = 2'd0;
  localparam logic [2:0]    c_OCC_FULL  = 3'd2;
  localparam logic [CW-1:0] c_XFER_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [W-1:0]  r_buf [2];
  logic          r_head;
  logic [1:0]    r_cnt;
  logic          r_inflight;
  logic [CW-1:0] r_xfer;

  logic          w_pop;
  logic [2:0]    w_occ;
  logic          w_room;
  logic          w_tail;

  assign w_pop = dout_valid & dout_ready;

  // Occupancy counts the word still in the FIFO pipeline, so a read is only
  // issued when the buffer is guaranteed a free slot on arrival.
  assign w_occ  = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_room = (w_occ < c_OCC_FULL) | (w_pop & (w_occ == c_OCC_FULL));
  assign re     = rst_n & ~rempty & w_room;

  // Slot after the current head; buf_cnt is never 2 when a capture lands.
  assign w_tail = r_head ^ r_cnt[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_head     <= 1'b0;
      r_cnt      <= c_CNT_EMPTY;
      r_inflight <= 1'b0;
      r_xfer     <= '0;
    end else begin
      if (r_inflight) begin
        r_buf[w_tail] <= rd;
      end
      if (w_pop) begin
        r_head <= ~r_head;
        r_xfer <= r_xfer + c_XFER_ONE;
      end
      r_cnt      <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      r_inflight <= re;
    end
  end

  assign dout       = r_buf[r_head];
  assign dout_valid = (r_cnt != c_CNT_EMPTY);
  assign xfer_cnt   = r_xfer;

endmodule
`default_nettype wire
